harris_window_buffer: RTL and testbench
=======================================

// Module: harris_window_buffer
// PURPOSE
//  Upstream feeder for the Harris-response stage. Accepts a raster-order 8-bit pixel stream and
//  buffers the last 5 image lines plus a 6x6 shift-register window. Presents a full 6x6 window with
//  a one-cycle win_valid strobe for every window position lying entirely inside the image.
//  Has no backpressure: the downstream Harris pipeline is free-running and takes one window per cycle.
// PARAMETERS
//  IMG_W   640  active pixels per line (>=6)
//  IMG_H   480  active lines per frame (>=6)
//  CNT_W   16   width of column/row counters and win_x/win_y
// PORTS
//  clk            in   1          system clock, all logic rising-edge
//  reset          in   1          synchronous, active-high
//  pix_valid      in   1          pix_data/sof valid this cycle
//  pix_data       in   8          pixel, unsigned
//  sof            in   1          start of frame, qualified by pix_valid; marks pixel (0,0)
//  window         out  8x[0:5][0:5]  window[r][c]; r=0 oldest line, c=0 oldest column
//  win_valid      out  1          one-cycle strobe: window holds a complete in-image 6x6 block
//  win_x          out  CNT_W      column of window[0][0] in the image
//  win_y          out  CNT_W      row of window[0][0] in the image
//  frame_done     out  1          one-cycle pulse with the update for pixel (IMG_W-1, IMG_H-1)
//  frame_err      out  1          one-cycle pulse: sof seen while counters not at (0,0)
//  win_count_last out  32         windows emitted in the last completed frame (see CONFIGURATION)
// BEHAVIOUR
//  - Counters col/row give the position of the next accepted pixel. On pix_valid: col++; at IMG_W-1
//    col->0 and row++; at (IMG_W-1, IMG_H-1) both wrap to 0.
//  - Five line buffers LB0..LB4, each IMG_W x 8, addressed by col. LB0 holds line row-1; LB4 holds
//    line row-5. On an accepted pixel, column vector v = {LB4[col],LB3[col],LB2[col],LB1[col],LB0[col],
//    pix_data} (v[0]=LB4 ... v[5]=pix_data). Write pix_data->LB0[col], LBk-1[col]->LBk[col]
//    (read-before-write, same cycle).
//  - Window shift (registered, 1-cycle latency): window[r][c] <= window[r][c+1] for c=0..4;
//    window[r][5] <= v[r]. No pix_valid -> window holds.
//  - win_valid registered with the window update; asserted iff the accepted pixel has col>=5 and
//    row>=5. Then win_x=col-5, win_y=row-5, registered alongside. Window never spans a line wrap.
//    Per frame: (IMG_W-5)*(IMG_H-5) strobes.
//  - frame_done: registered, asserted with the update for the last pixel of the frame.
//  - sof: pixel is forced to (0,0) (counters load 0, then advance to (1,0)). If the counters were
//    not at (0,0), frame_err pulses one cycle later. sof at (0,0) is silent; absence of sof is
//    tolerated (counters free-run).
//  - win_valid/frame_done/frame_err are low on every cycle without an accepted pixel.
//  - Reset: col=row=0. window all 0; win_valid, frame_done, and frame_err 0; win_x=win_y=0;
//    win_count_last=0. Line buffer contents are not reset. Stale data is masked by the row>=5 gate.
//    Reset mid-frame drops the partial frame. The next accepted pixel is (0,0).
//  - Reset takes priority over pix_valid in the same cycle; that pixel is discarded.
// CONFIGURATION
//  HARRIS_WINBUF_STATS_EN defined: a 32-bit counter increments on each win_valid. At frame_done its
//    final value, including that cycle's window, loads into win_count_last and the counter clears.
//    The counter also clears on reset and on a sof-resync.
//  Not defined: no counter logic; win_count_last is tied to 0. All other behaviour is identical.
// TESTING (bench params IMG_W=8, IMG_H=8; pixel value = 8*row+col)
//  1 reset, stream 64 px back-to-back with sof on px0 -> first win_valid 1 cycle after px45
//    (row5,col5): win_x=0, win_y=0, window[r][c]=8r+c. Next strobe: window[0][0]=1, win_x=1.
//    9 strobes total; frame_done 1 cycle after px63, with the last window win_x=2, win_y=2,
//    window[5][5]=63.
//  2 same frame with pix_valid every other cycle -> identical 9 windows and coords. Strobes never
//    back-to-back. Window is stable during gaps.
//  3 two frames back-to-back; second frame's values +100 -> frame 2 windows contain only frame-2
//    data (win_x=0, win_y=0 window[0][0]=100). frame_err never fires.
//  4 sof asserted on px20 of a frame -> frame_err pulse. px20 is treated as (0,0). The next 9 strobes
//    are relative to px20.
//  5 reset asserted while px50 is presented -> next cycle all outputs 0. px50 is dropped. No win_valid
//    until the 46th accepted pixel after reset.
//  6 HARRIS_WINBUF_STATS_EN defined -> win_count_last=9 after frame 1. Without the macro: stays 0.

Source files
------------

// File: rtl/harris_window_buffer_if.sv
// -----------------------------------------------------------------------------
// harris_window_buffer_if
//   Bundles the pixel input stream and the window output stream of the Harris
//   window buffer.
//
//   Signals
//     pix_valid       pixel/sof qualifier
//     pix_data[7:0]   unsigned pixel
//     sof             start of frame, marks pixel (0,0)
//     window          6x6 block, window[r][c], r=0 oldest line, c=0 oldest column
//     win_valid       one-cycle strobe for a complete in-image window
//     win_x/win_y     image position of window[0][0]
//     frame_done      pulse with the update for the last pixel of a frame
//     frame_err       pulse after a sof that arrived away from (0,0)
//     win_count_last  windows emitted in the last completed frame (0 if stats off)
//
//   Modports
//     master  pixel source / window consumer (testbench, upstream glue)
//     slave   the window buffer itself
// -----------------------------------------------------------------------------
interface harris_window_buffer_if #(
   parameter int CNT_W = 16
);
   logic                    pix_valid;
   logic [7:0]              pix_data;
   logic                    sof;
   logic [0:5][0:5][7:0]    window;
   logic                    win_valid;
   logic [CNT_W-1:0]        win_x;
   logic [CNT_W-1:0]        win_y;
   logic                    frame_done;
   logic                    frame_err;
   logic [31:0]             win_count_last;

   modport master (
      output pix_valid, pix_data, sof,
      input  window, win_valid, win_x, win_y, frame_done, frame_err, win_count_last
   );

   modport slave (
      input  pix_valid, pix_data, sof,
      output window, win_valid, win_x, win_y, frame_done, frame_err, win_count_last
   );
endinterface

// File: rtl/harris_window_buffer.sv
// -----------------------------------------------------------------------------
// harris_window_buffer
//   Feeder for the Harris-response stage. Takes a raster-order 8-bit pixel
//   stream, keeps the last five image lines in line memories plus a 6x6
//   shift-register window, and strobes win_valid for every window position
//   that lies completely inside the image. No backpressure: one window per
//   accepted pixel at most, consumer is free-running.
//
//   Ports
//     clk     rising-edge system clock
//     reset   synchronous, active-high; dominates an accepted pixel
//     bus     harris_window_buffer_if.slave (pixel input, window output)
//
//   Parameters
//     IMG_W   active pixels per line (>=6)
//     IMG_H   active lines per frame (>=6)
//     CNT_W   width of col/row counters and win_x/win_y
//
//   Optional feature
//     HARRIS_WINBUF_STATS_EN  when defined, counts strobes per frame and
//                             publishes the total on win_count_last at
//                             frame_done. Undefined: win_count_last is 0.
// -----------------------------------------------------------------------------
module harris_window_buffer #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   harris_window_buffer_if.slave bus
);

   localparam int               AW       = $clog2(IMG_W);
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] EDGE     = CNT_W'(5);

   // -------------------------------------------------------------------------
   // Position tracking
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] col_reg, row_reg;
   logic [CNT_W-1:0] col_next, row_next;
   logic [CNT_W-1:0] eff_col, eff_row;
   logic             accept;
   logic             resync;
   logic             at_last;
   logic             win_hit;
   logic             err_hit;
   logic [AW-1:0]    lb_addr;

   assign accept = bus.pix_valid;
   assign resync = bus.pix_valid && bus.sof;

   // A sof pixel is taken as (0,0) regardless of where the counters were, so
   // the effective position of the current pixel is what everything below uses.
   always_comb begin
      eff_col  = resync ? '0 : col_reg;
      eff_row  = resync ? '0 : row_reg;
      col_next = col_reg;
      row_next = row_reg;
      at_last  = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
      if (accept) begin
         if (eff_col == COL_LAST) begin
            col_next = '0;
            row_next = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
         end else begin
            col_next = eff_col + 1'b1;
            row_next = eff_row;
         end
      end
   end

   // Window is complete once five earlier lines and five earlier columns of
   // the current line are buffered; the column gate keeps windows off line wraps
   // and the row gate masks line-memory contents left from a previous frame.
   assign win_hit = accept && (eff_col >= EDGE) && (eff_row >= EDGE);
   assign err_hit = resync && ((col_reg != '0) || (row_reg != '0));
   assign lb_addr = eff_col[AW-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         col_reg <= '0;
         row_reg <= '0;
      end else begin
         col_reg <= col_next;
         row_reg <= row_next;
      end
   end

   // -------------------------------------------------------------------------
   // Line memories: LB0 holds line row-1 ... LB4 holds line row-5.
   // Each accepted pixel reads the column from all five memories and in the
   // same cycle pushes the column one line deeper (LBk-1 -> LBk). The read is
   // combinational because the freshly read column feeds the window update of
   // this same pixel, and a sof may move the address without warning, so the
   // address cannot be prefetched a cycle ahead.
   // Contents are deliberately not reset.
   // -------------------------------------------------------------------------
   logic [7:0] lb_rd   [0:4];
   logic [7:0] col_vec [0:5];   // col_vec[0] = oldest line, col_vec[5] = new pixel

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_lb
         logic [7:0] mem [0:IMG_W-1];
         logic [7:0] wr_data;

         if (gi == 0) begin : g_head
            assign wr_data = bus.pix_data;
         end else begin : g_chain
            assign wr_data = lb_rd[gi-1];
         end

         always_ff @(posedge clk) begin
            if (!reset && accept) begin
               mem[lb_addr] <= wr_data;
            end
         end

         assign lb_rd[gi]   = mem[lb_addr];
         assign col_vec[gi] = lb_rd[4-gi];
      end
   endgenerate

   assign col_vec[5] = bus.pix_data;

   // -------------------------------------------------------------------------
   // 6x6 window: every row shifts towards column 0 and takes the new column
   // vector at column 5. Holds when no pixel is accepted.
   // -------------------------------------------------------------------------
   logic [0:5][0:5][7:0] window_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         window_reg <= '0;
      end else if (accept) begin
         for (int r = 0; r < 6; r++) begin
            window_reg[r] <= {window_reg[r][1:5], col_vec[r]};
         end
      end
   end

   // -------------------------------------------------------------------------
   // Strobes and coordinates, registered together with the window update
   // -------------------------------------------------------------------------
   logic             win_valid_reg;
   logic             frame_done_reg;
   logic             frame_err_reg;
   logic [CNT_W-1:0] win_x_reg, win_y_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         win_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         win_x_reg      <= '0;
         win_y_reg      <= '0;
      end else begin
         win_valid_reg  <= win_hit;
         frame_done_reg <= accept && at_last;
         frame_err_reg  <= err_hit;
         if (win_hit) begin
            win_x_reg <= eff_col - EDGE;
            win_y_reg <= eff_row - EDGE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Per-frame window statistics
   // -------------------------------------------------------------------------
`ifdef HARRIS_WINBUF_STATS_EN
   logic [31:0] win_cnt_reg;
   logic [31:0] win_count_last_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt_reg        <= '0;
         win_count_last_reg <= '0;
      end else if (resync) begin
         // A sof pixel sits at (0,0) and can never carry a window itself.
         win_cnt_reg <= '0;
      end else if (accept && at_last) begin
         // Final total includes the window produced by the last pixel.
         win_count_last_reg <= win_cnt_reg + 32'(win_hit);
         win_cnt_reg        <= '0;
      end else if (win_hit) begin
         win_cnt_reg <= win_cnt_reg + 32'd1;
      end
   end

   assign bus.win_count_last = win_count_last_reg;
`else
   assign bus.win_count_last = '0;
`endif

   assign bus.window     = window_reg;
   assign bus.win_valid  = win_valid_reg;
   assign bus.win_x      = win_x_reg;
   assign bus.win_y      = win_y_reg;
   assign bus.frame_done = frame_done_reg;
   assign bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_harris_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_harris_window_buffer
//   Directed bench for harris_window_buffer with an 8x8 image. Pixel value is
//   base + 8*row + col, so every expected window is known in closed form.
// -----------------------------------------------------------------------------
module tb_harris_window_buffer;

   localparam int IMG_W = 8;
   localparam int IMG_H = 8;
   localparam int CNT_W = 16;

`ifdef HARRIS_WINBUF_STATS_EN
   localparam logic [31:0] EXP_STATS = 32'd9;
`else
   localparam logic [31:0] EXP_STATS = 32'd0;
`endif

   typedef logic [0:5][0:5][7:0] win_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   harris_window_buffer_if #(.CNT_W(CNT_W)) bus ();

   harris_window_buffer #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder: strobes, frame_done and frame_err with their cycle stamps
   win_t s_win [0:63];
   int   s_x   [0:63];
   int   s_y   [0:63];
   int   s_cyc [0:63];
   int   n_str = 0;
   int   fd_cyc [0:7];
   int   n_fd = 0;
   int   err_cyc [0:7];
   int   n_err = 0;

   always @(negedge clk) begin
      if (bus.win_valid === 1'b1) begin
         if (n_str < 64) begin
            s_win[n_str] = bus.window;
            s_x[n_str]   = int'(bus.win_x);
            s_y[n_str]   = int'(bus.win_y);
            s_cyc[n_str] = cyc;
         end
         n_str++;
      end
      if (bus.frame_done === 1'b1) begin
         if (n_fd < 8) fd_cyc[n_fd] = cyc;
         n_fd++;
      end
      if (bus.frame_err === 1'b1) begin
         if (n_err < 8) err_cyc[n_err] = cyc;
         n_err++;
      end
   end

   function automatic win_t exp_win(input int base, input int x, input int y);
      win_t w;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            w[r][c] = 8'(base + 8 * (y + r) + x + c);
      return w;
   endfunction

   task automatic clear_log();
      n_str = 0;
      n_fd  = 0;
      n_err = 0;
   endtask

   task automatic drive_px(input logic [7:0] d, input logic s, output int c);
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      bus.sof       = s;
      c = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.pix_valid = 1'b0;
         bus.sof       = 1'b0;
      end
   endtask

   // Streams one 8x8 frame; with gap set a dead cycle follows each pixel and
   // the window is checked to hold across it.
   task automatic send_frame(input int base, input logic with_sof, input logic gap,
                             output int c45, output int c63, output int c0, output int unstable);
      int   c;
      win_t snap;
      unstable = 0;
      c45 = 0; c63 = 0; c0 = 0;
      for (int i = 0; i < 64; i++) begin
         drive_px(8'(base + i), with_sof && (i == 0), c);
         if (gap && i > 0 && bus.window !== snap) unstable++;
         if (i == 0)  c0  = c;
         if (i == 45) c45 = c;
         if (i == 63) c63 = c;
         if (gap) begin
            idle(1);
            snap = bus.window;
         end
      end
   endtask

   task automatic check_frame(input int first, input int base, input string name);
      for (int k = 0; k < 9; k++) begin
         total++;
         if (s_win[first+k] !== exp_win(base, k % 3, k / 3) || s_x[first+k] != k % 3 ||
             s_y[first+k] != k / 3) begin
            bad++;
            $display("FAIL %s strobe %0d: got x=%0d y=%0d win=%h, need x=%0d y=%0d win=%h",
                     name, k, s_x[first+k], s_y[first+k], s_win[first+k],
                     k % 3, k / 3, exp_win(base, k % 3, k / 3));
         end
      end
   endtask

   task automatic check_idle_outputs(input string name);
      total++;
      if (bus.window !== '0 || bus.win_valid !== 1'b0 || bus.win_x !== '0 ||
          bus.win_y !== '0 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0 ||
          bus.win_count_last !== 32'd0) begin
         bad++;
         $display("FAIL %s: got wv=%b fd=%b fe=%b x=%0d y=%0d cnt=%0d win=%h, need all zero",
                  name, bus.win_valid, bus.frame_done, bus.frame_err, bus.win_x, bus.win_y,
                  bus.win_count_last, bus.window);
      end
   endtask

   task automatic check_int(input string name, input int got, input int need);
      total++;
      if (got != need) begin
         bad++;
         $display("FAIL %s: got %0d need %0d", name, got, need);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      reset         = 1'b1;
      bus.pix_valid = 1'b0;
      bus.pix_data  = 8'd0;
      bus.sof       = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_state");
      reset = 1'b0;
      idle(2);
      clear_log();
      $display("test_reset: done");
   endtask

   task automatic test_single_frame();
      int c45, c63, c0, unst;
      clear_log();
      send_frame(0, 1'b1, 1'b0, c45, c63, c0, unst);
      idle(3);
      check_int("single_strobe_count", n_str, 9);
      check_int("single_first_latency", s_cyc[0], c45 + 1);
      check_frame(0, 0, "single_frame");
      check_int("single_win00_second", int'(s_win[1][0][0]), 1);
      check_int("single_frame_done_count", n_fd, 1);
      check_int("single_frame_done_cycle", fd_cyc[0], c63 + 1);
      check_int("single_last_with_done", s_cyc[8], c63 + 1);
      check_int("single_last_win55", int'(s_win[8][5][5]), 63);
      check_int("single_no_err", n_err, 0);
      $display("test_single_frame: strobes=%0d", n_str);
   endtask

   task automatic test_gapped();
      int c45, c63, c0, unst, b2b;
      clear_log();
      send_frame(0, 1'b1, 1'b1, c45, c63, c0, unst);
      idle(3);
      check_int("gapped_strobe_count", n_str, 9);
      check_frame(0, 0, "gapped_frame");
      b2b = 0;
      for (int k = 1; k < 9; k++) if (s_cyc[k] - s_cyc[k-1] == 1) b2b++;
      check_int("gapped_back_to_back", b2b, 0);
      check_int("gapped_window_stable", unst, 0);
      check_int("gapped_frame_done", n_fd, 1);
      $display("test_gapped: strobes=%0d", n_str);
   endtask

   task automatic test_back_to_back();
      int c45, c63, c0, unst;
      clear_log();
      send_frame(0, 1'b1, 1'b0, c45, c63, c0, unst);
      send_frame(100, 1'b1, 1'b0, c45, c63, c0, unst);
      idle(3);
      check_int("b2b_strobe_count", n_str, 18);
      check_frame(0, 0, "b2b_frame1");
      check_frame(9, 100, "b2b_frame2");
      check_int("b2b_frame2_first_latency", s_cyc[9], c45 + 1);
      check_int("b2b_no_err", n_err, 0);
      check_int("b2b_frame_done_count", n_fd, 2);
      $display("test_back_to_back: strobes=%0d", n_str);
   endtask

   task automatic test_sof_resync();
      int c, c45, c63, c0, unst;
      clear_log();
      for (int i = 0; i < 20; i++) drive_px(8'(i), i == 0, c);
      send_frame(50, 1'b1, 1'b0, c45, c63, c0, unst);
      idle(3);
      check_int("resync_err_count", n_err, 1);
      check_int("resync_err_cycle", err_cyc[0], c0 + 1);
      check_int("resync_strobe_count", n_str, 9);
      check_frame(0, 50, "resync_frame");
      check_int("resync_frame_done", n_fd, 1);
      $display("test_sof_resync: strobes=%0d errs=%0d", n_str, n_err);
   endtask

   task automatic test_reset_mid_frame();
      int c, c45, c63, c0, unst;
      clear_log();
      for (int i = 0; i < 50; i++) drive_px(8'(i), i == 0, c);
      @(negedge clk);
      reset         = 1'b1;
      bus.pix_valid = 1'b1;
      bus.pix_data  = 8'd50;
      bus.sof       = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset_mid_frame_outputs");
      reset         = 1'b0;
      bus.pix_valid = 1'b0;
      clear_log();
      send_frame(30, 1'b0, 1'b0, c45, c63, c0, unst);
      idle(3);
      check_int("reset_mid_strobe_count", n_str, 9);
      check_int("reset_mid_first_latency", s_cyc[0], c45 + 1);
      check_frame(0, 30, "reset_mid_frame");
      check_int("reset_mid_no_err", n_err, 0);
      $display("test_reset_mid_frame: strobes=%0d", n_str);
   endtask

   task automatic test_stats();
      int c45, c63, c0, unst;
      clear_log();
      send_frame(7, 1'b1, 1'b0, c45, c63, c0, unst);
      idle(3);
      total++;
      if (bus.win_count_last !== EXP_STATS) begin
         bad++;
         $display("FAIL stats_win_count_last: got %0d need %0d", bus.win_count_last, EXP_STATS);
      end
      $display("test_stats: win_count_last=%0d", bus.win_count_last);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_gapped();
      test_back_to_back();
      test_sof_resync();
      test_reset_mid_frame();
      test_stats();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
